// File: rtl/sum_squares_if.sv
// Stream/control bundle for sum_squares: go/len start, element stream, result.
// HALF = WIDTH/2 is the element width.
interface sum_squares_if #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 8
);
  localparam int HALF = WIDTH / 2;

  logic                 go;
  logic [LEN_WIDTH-1:0] len;
  logic [HALF-1:0]      in;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out;
  logic                 done;
  logic                 overflow;

  modport master (
    output go, len, in, in_valid,
    input  in_ready, out, done, overflow
  );

  modport slave (
    input  go, len, in, in_valid,
    output in_ready, out, done, overflow
  );
endinterface

// File: rtl/sum_squares.sv
// Iterative sum-of-squares accumulator feeding a sqrt stage (done drives sqrt go).
// Define SUM_SQUARES_SATURATE_EN for a saturating sum with a sticky overflow flag.
module sum_squares #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  sum_squares_if.slave  bus
);
  localparam int HALF  = WIDTH / 2;
  localparam int BIT_W = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    MUL     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [HALF-1:0]      mult_q, mult_d;
  logic [WIDTH-1:0]     prod_q, prod_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     prod_next;
  logic [WIDTH-1:0]     acc_new;

`ifdef SUM_SQUARES_SATURATE_EN
  logic                 overflow_q, overflow_d;
  logic [WIDTH:0]       acc_sum;
`else
  logic [WIDTH-1:0]     acc_sum;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    prod_d      = prod_q;
    bit_d       = bit_q;
    out_d       = out_q;
    done_d      = done_q;
`ifdef SUM_SQUARES_SATURATE_EN
    overflow_d  = overflow_q;
`endif

    // Partial product including this cycle's bit; on the last MUL cycle it is the full square.
    prod_next = prod_q + (mult_q[bit_q] ? (mcand_q << bit_q) : '0);

`ifdef SUM_SQUARES_SATURATE_EN
    acc_sum = {1'b0, acc_q} + {1'b0, prod_next};
    acc_new = acc_sum[WIDTH] ? '1 : acc_sum[WIDTH-1:0];
`else
    acc_sum = acc_q + prod_next;
    acc_new = acc_sum;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          done_d      = 1'b0;
          acc_d       = '0;
          remaining_d = bus.len;
`ifdef SUM_SQUARES_SATURATE_EN
          overflow_d  = 1'b0;
`endif
          if (bus.len == '0) begin
            out_d  = '0;
            done_d = 1'b1;
          end else begin
            state_d = WAIT_IN;
          end
        end
      end

      WAIT_IN: begin
        if (bus.in_valid) begin
          mcand_d = {{(WIDTH - HALF){1'b0}}, bus.in};
          mult_d  = bus.in;
          prod_d  = '0;
          bit_d   = '0;
          state_d = MUL;
        end
      end

      MUL: begin
        prod_d = prod_next;
        bit_d  = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(HALF - 1)) begin
          acc_d       = acc_new;
          remaining_d = remaining_q - LEN_WIDTH'(1);
`ifdef SUM_SQUARES_SATURATE_EN
          overflow_d  = overflow_q | acc_sum[WIDTH];
`endif
          if (remaining_q == LEN_WIDTH'(1)) begin
            out_d   = acc_new;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      mcand_q     <= '0;
      mult_q      <= '0;
      prod_q      <= '0;
      bit_q       <= '0;
      out_q       <= '0;
      done_q      <= 1'b0;
`ifdef SUM_SQUARES_SATURATE_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      prod_q      <= prod_d;
      bit_q       <= bit_d;
      out_q       <= out_d;
      done_q      <= done_d;
`ifdef SUM_SQUARES_SATURATE_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == WAIT_IN);
  assign bus.out      = out_q;
  assign bus.done     = done_q;
`ifdef SUM_SQUARES_SATURATE_EN
  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule
